// File: rtl/video_timing_pkg.sv
// Shared video timing definitions for the timing generator and receiver.
// Holds the supported modelines, counter widths, the receiver lock FSM
// states and the coordinate-tagged pixel payload.
package video_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int unsigned VGA640_H_DISPLAY = 640;
    localparam int unsigned VGA640_H_FP      = 16;
    localparam int unsigned VGA640_H_SYNC    = 96;
    localparam int unsigned VGA640_H_TOTAL   = 800;
    localparam int unsigned VGA640_V_DISPLAY = 480;
    localparam int unsigned VGA640_V_FP      = 10;
    localparam int unsigned VGA640_V_SYNC    = 2;
    localparam int unsigned VGA640_V_TOTAL   = 525;

    // 1024x600 @ 60 Hz, 51.2 MHz pixel clock
    localparam int unsigned WSVGA_H_DISPLAY  = 1024;
    localparam int unsigned WSVGA_H_FP       = 160;
    localparam int unsigned WSVGA_H_SYNC     = 20;
    localparam int unsigned WSVGA_H_TOTAL    = 1344;
    localparam int unsigned WSVGA_V_DISPLAY  = 600;
    localparam int unsigned WSVGA_V_FP       = 12;
    localparam int unsigned WSVGA_V_SYNC     = 3;
    localparam int unsigned WSVGA_V_TOTAL    = 635;

    localparam int unsigned CNT_W   = 11;   // line / frame measurement counters
    localparam int unsigned COORD_W = 10;   // pixel coordinates
    localparam int unsigned RGB_W   = 24;
    localparam int unsigned GOOD_W  = 4;    // good-frame counter, LOCK_FRAMES <= 15

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic               de;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [RGB_W-1:0]   rgb;
    } pixel_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync/enable input and flags its falling edge.
// Ports: clock, reset_n (async active-low), d (raw input),
//        q (registered copy), fall_c (high while q has just dropped 1->0).
module sync_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic fall_c
);

    logic q_prev;

    // Input register plus one-cycle history for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q      <= 1'b0;
            q_prev <= 1'b0;
        end else begin
            q      <= d;
            q_prev <= q;
        end
    end

    assign fall_c = q_prev & ~q;

endmodule

// File: rtl/vga_timing_rx.sv
// Receive-side VGA/HDMI timing recovery. Registers the incoming sync/DE/RGB
// stream, recovers pixel coordinates, measures line and frame totals and
// locks once LOCK_FRAMES consecutive frames match the expected modeline.
// Ports: clock, reset_n (async active-low); hsync, vsync (active-low pulses),
//        dataEnable, RGBchannel[23:0] in; pixel_x/pixel_y/pixel_rgb/pixel_valid
//        coordinate-tagged pixel out (2-clock latency); frame_start and
//        timing_error pulses; locked; h_total_meas/v_total_meas measurements.
module vga_timing_rx
    import video_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY   = VGA640_H_DISPLAY,
    parameter int unsigned H_TOTAL     = VGA640_H_TOTAL,
    parameter int unsigned V_DISPLAY   = VGA640_V_DISPLAY,
    parameter int unsigned V_TOTAL     = VGA640_V_TOTAL,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         hsync,
    input  logic         vsync,
    input  logic         dataEnable,
    input  logic [23:0]  RGBchannel,
    output logic [9:0]   pixel_x,
    output logic [9:0]   pixel_y,
    output logic [23:0]  pixel_rgb,
    output logic         pixel_valid,
    output logic         frame_start,
    output logic         locked,
    output logic         timing_error,
    output logic [10:0]  h_total_meas,
    output logic [10:0]  v_total_meas
);

    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [COORD_W-1:0] COORD_MAX   = '1;
    localparam logic [CNT_W-1:0]   H_TOTAL_C   = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0]   V_TOTAL_C   = CNT_W'(V_TOTAL);
    localparam logic [COORD_W-1:0] H_DISPLAY_C = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_DISPLAY_C = COORD_W'(V_DISPLAY);
    localparam logic [GOOD_W-1:0]  LOCK_C      = GOOD_W'(LOCK_FRAMES);

    // Stage 1: registered inputs and edge pulses
    logic             hs_q, vs_q, de_q;
    logic             hs_fall_c, vs_fall_c, de_fall_c;
    logic [RGB_W-1:0] rgb_q;

    sync_edge_detect u_hs_edge (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (hsync),
        .q      (hs_q),
        .fall_c (hs_fall_c)
    );

    sync_edge_detect u_vs_edge (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (vsync),
        .q      (vs_q),
        .fall_c (vs_fall_c)
    );

    sync_edge_detect u_de_edge (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (dataEnable),
        .q      (de_q),
        .fall_c (de_fall_c)
    );

    // Only the edges of the sync lines matter here
    logic unused_sync_levels;
    assign unused_sync_levels = &{1'b0, hs_q, vs_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rgb_q <= '0;
        else          rgb_q <= RGBchannel;
    end

    // Stage 2: counters, measurements, frame check and lock FSM
    logic [CNT_W-1:0]   h_cnt, v_cnt, h_meas, v_meas;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic               frame_bad;
    logic [GOOD_W-1:0]  good_cnt, good_cnt_next;
    rx_state_e          state, state_next;
    pixel_t             px;
    logic               fs_q, err_q, err_c;

    logic [CNT_W-1:0]   h_close_c, v_close_c;
    logic [COORD_W-1:0] runs_close_c;
    logic               line_bad_c, run_bad_c, frame_good_c;

    // Values closing the current line/frame, including events landing on the vsync fall
    always_comb begin
        h_close_c    = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + CNT_W'(1);
        v_close_c    = v_cnt;
        runs_close_c = y_cnt;
        if (hs_fall_c && v_cnt != CNT_MAX) v_close_c = v_cnt + CNT_W'(1);
        if (de_fall_c && y_cnt != COORD_MAX) runs_close_c = y_cnt + COORD_W'(1);
        line_bad_c   = hs_fall_c && (h_close_c != H_TOTAL_C);
        run_bad_c    = de_fall_c && (x_cnt != H_DISPLAY_C);
        frame_good_c = !(frame_bad || line_bad_c || run_bad_c)
                       && (v_close_c == V_TOTAL_C)
                       && (runs_close_c == V_DISPLAY_C);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            h_meas    <= '0;
            v_meas    <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            frame_bad <= 1'b0;
            px        <= '0;
            fs_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (hs_fall_c) begin
                h_cnt  <= '0;
                h_meas <= h_close_c;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + CNT_W'(1);
            end

            if (vs_fall_c) begin
                v_cnt  <= '0;
                v_meas <= v_close_c;
            end else if (hs_fall_c && v_cnt != CNT_MAX) begin
                v_cnt <= v_cnt + CNT_W'(1);
            end

            // x_cnt holds the column of the pixel now in stage 1
            if (de_fall_c) begin
                x_cnt <= '0;
            end else if (de_q && x_cnt != COORD_MAX) begin
                x_cnt <= x_cnt + COORD_W'(1);
            end

            if (vs_fall_c) begin
                y_cnt <= '0;
            end else if (de_fall_c && y_cnt != COORD_MAX) begin
                y_cnt <= y_cnt + COORD_W'(1);
            end

            if (vs_fall_c) begin
                frame_bad <= 1'b0;
            end else if (line_bad_c || run_bad_c) begin
                frame_bad <= 1'b1;
            end

            px.de  <= de_q;
            px.x   <= x_cnt;
            px.y   <= y_cnt;
            px.rgb <= rgb_q;
            fs_q   <= vs_fall_c;
            err_q  <= err_c;
        end
    end

    // Lock FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
        end
    end

    // Lock FSM next state; frames are only judged at a vsync fall
    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        err_c         = 1'b0;
        if (vs_fall_c) begin
            unique case (state)
                ST_SEARCH: begin
                    state_next    = ST_TRACK;
                    good_cnt_next = '0;
                end
                ST_TRACK: begin
                    if (!frame_good_c) begin
                        good_cnt_next = '0;
                    end else if (good_cnt + GOOD_W'(1) >= LOCK_C) begin
                        state_next    = ST_LOCKED;
                        good_cnt_next = '0;
                    end else begin
                        good_cnt_next = good_cnt + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good_c) begin
                        state_next    = ST_TRACK;
                        good_cnt_next = '0;
                        err_c         = 1'b1;
                    end
                end
                default: begin
                    state_next    = ST_SEARCH;
                    good_cnt_next = '0;
                end
            endcase
        end
    end

    // Stage 3: output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x      <= '0;
            pixel_y      <= '0;
            pixel_rgb    <= '0;
            pixel_valid  <= 1'b0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            timing_error <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
        end else begin
            pixel_x      <= px.x;
            pixel_y      <= px.y;
            pixel_rgb    <= px.rgb;
            pixel_valid  <= px.de && (state == ST_LOCKED);
            frame_start  <= fs_q;
            locked       <= (state == ST_LOCKED);
            timing_error <= err_q;
            h_total_meas <= h_meas;
            v_total_meas <= v_meas;
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Self-checking bench for vga_timing_rx using a reduced modeline
// (16/24 pixels, 6/10 lines) so many frames fit in a short run.
module tb_vga_timing_rx;

    localparam int unsigned HD   = 16;
    localparam int unsigned HT   = 24;
    localparam int unsigned VD   = 6;
    localparam int unsigned VT   = 10;
    localparam int unsigned LF   = 2;
    localparam int unsigned HS_S = 18;
    localparam int unsigned HS_W = 3;
    localparam int unsigned VS_L = 7;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        dataEnable = 1'b0;
    logic [23:0] RGBchannel = '0;
    logic [9:0]  pixel_x, pixel_y;
    logic [23:0] pixel_rgb;
    logic        pixel_valid, frame_start, locked, timing_error;
    logic [10:0] h_total_meas, v_total_meas;

    always #5 clock = ~clock;

    vga_timing_rx #(
        .H_DISPLAY  (HD),
        .H_TOTAL    (HT),
        .V_DISPLAY  (VD),
        .V_TOTAL    (VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .dataEnable  (dataEnable),
        .RGBchannel  (RGBchannel),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_rgb   (pixel_rgb),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .locked      (locked),
        .timing_error(timing_error),
        .h_total_meas(h_total_meas),
        .v_total_meas(v_total_meas)
    );

    typedef struct packed {
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Stream generator state
    int h = 0, v = 0, vt = VT, cyc = 0, nvs = 0;
    bit prev_vs = 1'b1, prev_hs = 1'b1, vs_fell = 1'b0, hs_fell = 1'b0;
    bit hold_hs = 1'b0, short_arm = 1'b0;
    bit track_xy = 1'b0, chk_valid = 1'b0, ever_locked = 1'b0;
    int valid_cnt = 0, te_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive at negedge, sample 1 time unit after posedge
    task automatic tick();
        logic        hs_i, vs_i, de_i;
        logic [23:0] rgb_i;
        int          lin, de_len;
        exp_t        e, p;
        @(negedge clock);
        cyc++;
        lin    = v * HT + h;
        de_len = (short_arm && v == 2) ? HD - 1 : HD;
        hs_i   = hold_hs || !(h >= HS_S && h < HS_S + HS_W);
        vs_i   = !(lin >= VS_L * HT + HS_S && lin < (VS_L + 2) * HT + HS_S);
        de_i   = (v < VD) && (h < de_len);
        rgb_i  = 24'($urandom);
        hsync      = hs_i;
        vsync      = vs_i;
        dataEnable = de_i;
        RGBchannel = rgb_i;
        vs_fell = prev_vs && !vs_i;
        hs_fell = prev_hs && !hs_i;
        prev_vs = vs_i;
        prev_hs = hs_i;
        if (vs_fell) nvs++;
        e.de  = de_i;
        e.x   = 10'(h);
        e.y   = 10'(v);
        e.rgb = rgb_i;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() >= 3) begin
            p = sb.pop_front();
            if (track_xy && p.de) begin
                chk("pix_x", 32'(pixel_x), 32'(p.x));
                chk("pix_y", 32'(pixel_y), 32'(p.y));
                chk("pix_rgb", 32'(pixel_rgb), 32'(p.rgb));
            end
            if (chk_valid) chk("pix_valid", 32'(pixel_valid), 32'(p.de));
        end
        if (pixel_valid) valid_cnt++;
        if (timing_error) te_cnt++;
        if (locked) ever_locked = 1'b1;
        if (vs_fell) track_xy = 1'b1;
        if (short_arm && v == 2 && h == HT - 1) short_arm = 1'b0;
        h++;
        if (h == HT) begin
            h = 0;
            v++;
            if (v >= vt) v = 0;
        end
    endtask

    task automatic run_to_vs(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * HT * 11 && !hit; i++) begin
            tick();
            if (vs_fell && nvs == n) hit = 1'b1;
        end
        chk("vs_reached", 32'(nvs), 32'(n));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"},   32'(pixel_x), 0);
        chk({tag, "_y"},   32'(pixel_y), 0);
        chk({tag, "_rgb"}, 32'(pixel_rgb), 0);
        chk({tag, "_pv"},  32'(pixel_valid), 0);
        chk({tag, "_fs"},  32'(frame_start), 0);
        chk({tag, "_lk"},  32'(locked), 0);
        chk({tag, "_te"},  32'(timing_error), 0);
        chk({tag, "_hm"},  32'(h_total_meas), 0);
        chk({tag, "_vm"},  32'(v_total_meas), 0);
    endtask

    // Called right after the 3rd vsync fall since reset: lock appears 2 clocks later
    task automatic chk_lock_third(input string tag);
        tick();
        chk({tag, "_lk_n1"}, 32'(locked), 0);
        chk({tag, "_fs_n1"}, 32'(frame_start), 0);
        tick();
        chk({tag, "_lk_n2"}, 32'(locked), 1);
        chk({tag, "_fs_n2"}, 32'(frame_start), 1);
        chk({tag, "_vmeas"}, 32'(v_total_meas), VT);
        chk({tag, "_hmeas"}, 32'(h_total_meas), HT);
        tick();
        chk({tag, "_fs_n3"}, 32'(frame_start), 0);
    endtask

    task automatic start_reset();
        reset_n     = 1'b0;
        track_xy    = 1'b0;
        chk_valid   = 1'b0;
        ever_locked = 1'b0;
        nvs         = 0;
        sb.delete();
    endtask

    initial begin
        // Reset state
        start_reset();
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Acquire lock on a standard stream
        run_to_vs(3);
        chk_lock_third("acq");

        // Locked frames: every DE pixel tagged, valid exactly HD*VD per frame
        chk_valid = 1'b1;
        valid_cnt = 0;
        run_to_vs(4);
        chk("valid_f4", 32'(valid_cnt), HD * VD);
        valid_cnt = 0;
        run_to_vs(5);
        chk("valid_f5", 32'(valid_cnt), HD * VD);
        chk_valid = 1'b0;

        // One short DE run: error at the next vsync fall, relock after 2 good frames
        short_arm = 1'b1;
        te_cnt    = 0;
        run_to_vs(6);
        tick();
        chk("bad_te_n1", 32'(timing_error), 0);
        chk("bad_lk_n1", 32'(locked), 1);
        tick();
        chk("bad_te_n2", 32'(timing_error), 1);
        chk("bad_lk_n2", 32'(locked), 0);
        tick();
        chk("bad_te_n3", 32'(timing_error), 0);
        run_to_vs(7);
        tick();
        tick();
        chk("relock_f1", 32'(locked), 0);
        run_to_vs(8);
        tick();
        chk("relock_n1", 32'(locked), 0);
        tick();
        chk("relock_n2", 32'(locked), 1);
        chk("te_once", 32'(te_cnt), 1);

        // Mid-line reset while locked
        for (int i = 0; i < 4 * HT * 11 && !(v == 3 && h == 8); i++) tick();
        chk("pre_rst_valid", 32'(pixel_valid), 1);
        start_reset();
        #1;
        chk_all_zero("midrst");
        tick();
        tick();
        reset_n = 1'b1;
        run_to_vs(3);
        chk_lock_third("reacq");

        // hsync stuck high: h_cnt saturates, never locks
        start_reset();
        hold_hs = 1'b1;
        tick();
        reset_n = 1'b1;
        repeat (3000) tick();
        chk("hold_lock", 32'(ever_locked), 0);
        chk("hold_hmeas0", 32'(h_total_meas), 0);
        hold_hs = 1'b0;
        for (int i = 0; i < 2 * HT && !hs_fell; i++) tick();
        tick();
        tick();
        chk("hold_hmeas_sat", 32'(h_total_meas), 2047);
        chk("hold_lock_after", 32'(locked), 0);

        // One extra line per frame: measured but never locks
        start_reset();
        vt = VT + 1;
        tick();
        reset_n = 1'b1;
        run_to_vs(3);
        tick();
        tick();
        chk("vt_vmeas", 32'(v_total_meas), VT + 1);
        chk("vt_hmeas", 32'(h_total_meas), HT);
        run_to_vs(5);
        tick();
        tick();
        chk("vt_never_locked", 32'(ever_locked), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_rx.md
# vga_timing_rx

Receive-side counterpart of the VGA/HDMI timing generator. Samples an incoming hsync/vsync/dataEnable/RGB stream on the pixel clock and recovers pixel coordinates. Measures line and frame totals, checks them against the expected modeline and raises `locked` once the stream is stable. Sits at the front of capture, loopback-check and overlay paths and feeds downstream logic with coordinate-tagged pixels.

## Interface
Parameters:
- `H_DISPLAY`, 640, active pixels per line
- `H_TOTAL`, 800, clocks per line
- `V_DISPLAY`, 480, active lines per frame
- `V_TOTAL`, 525, lines per frame
- `LOCK_FRAMES`, 2, consecutive good frames required to lock (1..15)

Ports:
- `clock`  in  1  pixel clock (25 MHz for 640x480)
- `reset_n`  in  1  asynchronous, active-low reset
- `hsync`  in  1  horizontal sync, active-low pulse
- `vsync`  in  1  vertical sync, active-low pulse
- `dataEnable`  in  1  high during active pixels
- `RGBchannel`  in  24  pixel data, [23:16] R, [15:8] G, [7:0] B
- `pixel_x`  out  10  column of current active pixel
- `pixel_y`  out  10  row of current active pixel
- `pixel_rgb`  out  24  RGB aligned with `pixel_x`/`pixel_y`
- `pixel_valid`  out  1  active pixel present and `locked`
- `frame_start`  out  1  one-cycle pulse on each vsync falling edge
- `locked`  out  1  stream matches parameters
- `timing_error`  out  1  one-cycle pulse when a checked frame fails
- `h_total_meas`  out  11  clocks in last complete line
- `v_total_meas`  out  11  lines in last complete frame

## Operation
- Stage 1 registers all inputs. Falling edges of `hsync` and `vsync` and the falling edge of `dataEnable` are detected on the registered copies.
- `h_cnt` (11 b) increments every clock. On an hsync fall, `h_total_meas <= h_cnt + 1` and `h_cnt <= 0`. `h_cnt` saturates at 2047.
- `v_cnt` (11 b) increments on each hsync fall. On a vsync fall, `v_total_meas <= v_cnt + 1` if an hsync fall occurs in the same cycle, otherwise `v_total_meas <= v_cnt`. `v_cnt <= 0` on a vsync fall. `v_cnt` saturates at 2047.
- `x_cnt` counts registered-DE-high cycles and clears on a DE fall. `pixel_x = x_cnt`, saturating at 1023.
- `y_cnt` increments on each DE fall, clears on a vsync fall, and saturates at 1023. `pixel_y = y_cnt`.
- Per-frame sticky `frame_bad` is set by either of:
  - any DE run with length ≠ `H_DISPLAY`;
  - any line with `h_total_meas` ≠ `H_TOTAL`.
- At a vsync fall the frame is good when all of the following hold:
  - `frame_bad` is clear;
  - the closing `v_total_meas` = `V_TOTAL`;
  - the DE-run count = `V_DISPLAY`.
- `frame_bad` then clears.
- FSM:
  - SEARCH (reset state): on the first vsync fall go to TRACK with `good_cnt = 0`. No check is made on this partial frame.
  - TRACK: at each vsync fall, a good frame increments `good_cnt`, and reaching `LOCK_FRAMES` goes to LOCKED. A bad frame clears `good_cnt` and stays in TRACK.
  - LOCKED: a good frame stays. A bad frame goes to TRACK with `good_cnt = 0` and pulses `timing_error`.
- `locked` = (state == LOCKED). `pixel_valid` = registered DE AND `locked`.
- A `reset_n` assertion at any time forces SEARCH, clears all counters and flags, and drives every output to 0.

## Timing
- Input sampled at edge k; the corresponding `pixel_x`/`pixel_y`/`pixel_rgb`/`pixel_valid` appear after edge k+2. Latency is 2 clocks, with no bubbles.
- `frame_start`, `timing_error`, `v_total_meas` and `locked` update 2 clocks after the vsync-fall sample.
- `locked` falls in the same cycle that `timing_error` pulses.
- Simultaneous hsync and vsync falls (the normal case for the team's generator) count as one line closing the old frame.
- DE spanning a vsync fall: `y_cnt` clears, and the run still counts toward the new frame.
- Reset values: all outputs 0; `h_total_meas` = `v_total_meas` = 0.

## Structure
- Shared package `video_timing_pkg` holds:
  - the 640x480 and 1024x600 modeline constants, shared with the generator;
  - the FSM state enum (SEARCH, TRACK, LOCKED).
- Sub-module `sync_edge_detect` (register plus falling-edge pulse), instantiated for hsync, vsync and dataEnable.

## Test plan
- Standard 640x480 stream from the generator model, 4 frames:
  - `locked` rises 2 clocks after the 3rd vsync fall;
  - `h_total_meas` = 800 and `v_total_meas` = 525.
- While locked:
  - first DE pixel gives (`pixel_x`, `pixel_y`) = (0,0) with RGB passthrough 2 clocks later;
  - last DE pixel gives (639,479);
  - `pixel_valid` is high for exactly 307200 cycles per frame.
- Shorten one DE run to 639 cycles in frame 5:
  - `timing_error` pulses once and `locked` drops at the next vsync fall;
  - `locked` re-asserts after 2 further good frames.
- Hold hsync high for 3000 clocks: `h_cnt` saturates at 2047 and `locked` stays 0.
- Assert `reset_n` low mid-line during LOCKED:
  - all outputs go to 0 immediately;
  - after release, lock is reacquired at the 3rd vsync fall.
- Stream with `V_TOTAL` = 526: `v_total_meas` = 526 and the block never locks.
